mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscy_mem_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscy_mem_pkg.sv
// Shared memory-side types for the riscy core: address/data widths and the
// response-owner encoding used by the fetch and load/store units.
package riscy_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DRD  = 2'd2,
    RESP_DWR  = 2'd3
  } resp_sel_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port registered RAM: load/store wins by
// default, fetch is guaranteed a slot after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int ADDR_W     = riscy_mem_pkg::ADDR_W,
  parameter int DATA_W     = riscy_mem_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_out
);

  import riscy_mem_pkg::*;

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  resp_sel_t        resp_sel, resp_next;
  logic [CNT_W-1:0] starve_cnt, cnt_next;
  logic             starve_full;

  // Grants, RAM drive and next-state; the response owner remembers which
  // port the RAM output belongs to on the following cycle.
  always_comb begin
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    starve_full = (starve_cnt == STARVE_LIM);
    if (!rst) begin
      if (d_req && !(i_req && starve_full))
        d_gnt = 1'b1;
      else if (i_req)
        i_gnt = 1'b1;
    end

    ram_write = d_gnt & d_we;
    ram_addr  = '0;
    if (i_gnt)
      ram_addr = i_addr;
    else if (d_gnt)
      ram_addr = d_addr;
    ram_data = d_gnt ? d_wdata : '0;

    resp_next = RESP_NONE;
    if (i_gnt)
      resp_next = RESP_IF;
    else if (d_gnt)
      resp_next = d_we ? RESP_DWR : RESP_DRD;

    cnt_next = starve_cnt;
    if (i_gnt || !i_req)
      cnt_next = '0;
    else if (d_gnt && !starve_full)
      cnt_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_sel   <= RESP_NONE;
      starve_cnt <= '0;
    end else begin
      resp_sel   <= resp_next;
      starve_cnt <= cnt_next;
    end
  end

  // Write responses return zero data since the RAM output is meaningless then.
  assign i_rvalid = (resp_sel == RESP_IF);
  assign d_done   = (resp_sel == RESP_DRD) || (resp_sel == RESP_DWR);
  assign i_rdata  = (resp_sel == RESP_IF)  ? ram_out : '0;
  assign d_rdata  = (resp_sel == RESP_DRD) ? ram_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a shadow-memory reference model, with a behavioural RAM attached.
module tb_mem_arbiter;

  import riscy_mem_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_out;

  logic          tb_load;
  logic [AW-1:0] tb_load_addr;
  logic [DW-1:0] tb_load_data;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:63];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
  );

  // Registered single-port RAM owned by the parent, with a bench preload port.
  always @(posedge clk) begin
    if (ram_write)
      mem[ram_addr] <= ram_data;
    else if (tb_load)
      mem[tb_load_addr] <= tb_load_data;
    ram_out <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      tb_load = 1'b1;
      tb_load_addr = AW'(i);
      tb_load_data = $urandom;
      shadow[i] = tb_load_data;
      d_addr = AW'($urandom_range(0, 63));
      d_wdata = $urandom;
      #1;
      n_cmp++; if (i_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_i_gnt: got %b want 0", i_gnt); end
      n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_d_gnt: got %b want 0", d_gnt); end
      n_cmp++; if (ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ram_write: got %b want 0", ram_write); end
      tick();
    end
    tb_load = 1'b0; rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    n_cmp++; if (i_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_i_rvalid: got %b want 0", i_rvalid); end
    n_cmp++; if (d_done !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_d_done: got %b want 0", d_done); end
    n_cmp++; if (dut.resp_sel !== RESP_NONE) begin n_fail++; $display("[TB] FAIL post_rst_resp_sel: got %0d want 0", dut.resp_sel); end
    n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL post_rst_starve: got %0d want 0", dut.starve_cnt); end
    tick();
  endtask

  task automatic test_fetch();
    tb_load = 1'b1; tb_load_addr = 12'h005; tb_load_data = 32'h0000abba;
    shadow[5] = 32'h0000abba;
    tick();
    tb_load = 1'b0;
    i_req = 1'b1; i_addr = 12'h005;
    #1;
    n_cmp++; if (i_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL fetch_i_gnt: got %b want 1", i_gnt); end
    n_cmp++; if (d_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_d_gnt: got %b want 0", d_gnt); end
    n_cmp++; if (ram_addr !== 12'h005) begin n_fail++; $display("[TB] FAIL fetch_ram_addr: got %h want 005", ram_addr); end
    tick();
    i_req = 1'b0;
    #1;
    n_cmp++; if (i_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL fetch_i_rvalid: got %b want 1", i_rvalid); end
    n_cmp++; if (i_rdata !== 32'h0000abba) begin n_fail++; $display("[TB] FAIL fetch_i_rdata: got %h want 0000abba", i_rdata); end
    n_cmp++; if (d_done !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_d_done: got %b want 0", d_done); end
    tick();
    n_cmp++; if (i_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_pulse_width: got %b want 0", i_rvalid); end
  endtask

  task automatic test_store_load();
    logic [DW-1:0] rd_wdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h010; d_wdata = 32'h0000fefe;
    #1;
    n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL store_d_gnt: got %b want 1", d_gnt); end
    n_cmp++; if (ram_write !== 1'b1) begin n_fail++; $display("[TB] FAIL store_ram_write: got %b want 1", ram_write); end
    n_cmp++; if (ram_addr !== 12'h010) begin n_fail++; $display("[TB] FAIL store_ram_addr: got %h want 010", ram_addr); end
    n_cmp++; if (ram_data !== 32'h0000fefe) begin n_fail++; $display("[TB] FAIL store_ram_data: got %h want 0000fefe", ram_data); end
    shadow[16] = 32'h0000fefe;
    tick();
    rd_wdata = $urandom;
    d_we = 1'b0; d_wdata = rd_wdata;
    #1;
    n_cmp++; if (d_done !== 1'b1) begin n_fail++; $display("[TB] FAIL store_d_done: got %b want 1", d_done); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL store_d_rdata: got %h want 0", d_rdata); end
    n_cmp++; if (ram_write !== 1'b0) begin n_fail++; $display("[TB] FAIL load_ram_write: got %b want 0", ram_write); end
    n_cmp++; if (ram_data !== rd_wdata) begin n_fail++; $display("[TB] FAIL load_ram_data: got %h want %h", ram_data, rd_wdata); end
    tick();
    d_req = 1'b0;
    #1;
    n_cmp++; if (d_done !== 1'b1) begin n_fail++; $display("[TB] FAIL load_d_done: got %b want 1", d_done); end
    n_cmp++; if (d_rdata !== 32'h0000fefe) begin n_fail++; $display("[TB] FAIL load_d_rdata: got %h want 0000fefe", d_rdata); end
    tick();
  endtask

  task automatic test_contention();
    bit            exp_i, prev_iv, prev_dv;
    logic [DW-1:0] prev_id, prev_dd;
    prev_iv = 1'b0; prev_dv = 1'b0; prev_id = '0; prev_dd = '0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = AW'($urandom_range(0, 63));
    for (int k = 0; k < 15; k++) begin
      d_addr = AW'($urandom_range(0, 63));
      d_wdata = $urandom;
      #1;
      exp_i = ((k % 5) == 4);
      n_cmp++; if (i_gnt !== exp_i) begin n_fail++; $display("[TB] FAIL cont_i_gnt[%0d]: got %b want %b", k, i_gnt, exp_i); end
      n_cmp++; if (d_gnt !== !exp_i) begin n_fail++; $display("[TB] FAIL cont_d_gnt[%0d]: got %b want %b", k, d_gnt, !exp_i); end
      if (exp_i) begin
        n_cmp++; if (dut.starve_cnt !== 3'(SMAX)) begin n_fail++; $display("[TB] FAIL cont_starve[%0d]: got %0d want %0d", k, dut.starve_cnt, SMAX); end
      end
      n_cmp++; if (i_rvalid !== prev_iv || i_rdata !== prev_id) begin n_fail++; $display("[TB] FAIL cont_i_resp[%0d]: got %b/%h want %b/%h", k, i_rvalid, i_rdata, prev_iv, prev_id); end
      n_cmp++; if (d_done !== prev_dv || d_rdata !== prev_dd) begin n_fail++; $display("[TB] FAIL cont_d_resp[%0d]: got %b/%h want %b/%h", k, d_done, d_rdata, prev_dv, prev_dd); end
      prev_iv = exp_i;
      prev_id = exp_i ? shadow[i_addr[5:0]] : '0;
      prev_dv = !exp_i;
      prev_dd = exp_i ? '0 : shadow[d_addr[5:0]];
      tick();
      if (exp_i) i_addr = AW'($urandom_range(0, 63));
    end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++; if (d_done !== prev_dv || d_rdata !== prev_dd) begin n_fail++; $display("[TB] FAIL cont_d_last: got %b/%h want %b/%h", d_done, d_rdata, prev_dv, prev_dd); end
    tick();
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 12'h007; d_addr = 12'h008;
    #1;
    n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL sim_starve: got %0d want 0", dut.starve_cnt); end
    n_cmp++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_grant: got d=%b i=%b want d=1 i=0", d_gnt, i_gnt); end
    tick();
    d_req = 1'b0;
    #1;
    n_cmp++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_held_fetch: got i=%b d=%b want i=1 d=0", i_gnt, d_gnt); end
    n_cmp++; if (ram_addr !== 12'h007) begin n_fail++; $display("[TB] FAIL sim_ram_addr: got %h want 007", ram_addr); end
    n_cmp++; if (d_rdata !== shadow[8]) begin n_fail++; $display("[TB] FAIL sim_d_rdata: got %h want %h", d_rdata, shadow[8]); end
    tick();
    i_req = 1'b0;
    #1;
    n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== shadow[7]) begin n_fail++; $display("[TB] FAIL sim_i_resp: got %b/%h want 1/%h", i_rvalid, i_rdata, shadow[7]); end
    tick();
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 12'h003; d_addr = 12'h004;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_grant: got d=%b i=%b want 0/0", d_gnt, i_gnt); end
    tick();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++; if (d_done !== 1'b0 || i_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_resp: got d=%b i=%b want 0/0", d_done, i_rvalid); end
    n_cmp++; if (dut.resp_sel !== RESP_NONE) begin n_fail++; $display("[TB] FAIL mid_rst_resp_sel: got %0d want 0", dut.resp_sel); end
    n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL mid_rst_starve: got %0d want 0", dut.starve_cnt); end
    tick();
  endtask

  task automatic test_idle();
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_addr = AW'($urandom); d_addr = AW'($urandom); d_we = 1'($urandom); d_wdata = $urandom;
      #1;
      n_cmp++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_grant[%0d]: got i=%b d=%b want 0/0", k, i_gnt, d_gnt); end
      n_cmp++; if (ram_write !== 1'b0 || ram_addr !== '0 || ram_data !== '0) begin n_fail++; $display("[TB] FAIL idle_ram[%0d]: got %b/%h/%h want 0/0/0", k, ram_write, ram_addr, ram_data); end
      n_cmp++; if (i_rvalid !== 1'b0 || d_done !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valid[%0d]: got i=%b d=%b want 0/0", k, i_rvalid, d_done); end
      tick();
    end
  endtask

  task automatic test_random();
    int            m_cnt;
    bit            want_i, want_d, exp_iv, exp_dv, exp_we;
    logic [DW-1:0] exp_id, exp_dd, exp_data;
    logic [AW-1:0] exp_addr;
    m_cnt = 0; exp_iv = 1'b0; exp_dv = 1'b0; exp_id = '0; exp_dd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!i_req) begin
        i_req = 1'($urandom_range(0, 1));
        i_addr = AW'($urandom_range(0, 63));
      end
      if (!d_req) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      #1;
      want_d = d_req && !(i_req && m_cnt == SMAX);
      want_i = i_req && !want_d;
      exp_we = want_d && d_we;
      exp_addr = want_i ? i_addr : (want_d ? d_addr : '0);
      exp_data = want_d ? d_wdata : '0;
      n_cmp++; if (i_gnt !== want_i || d_gnt !== want_d) begin n_fail++; $display("[TB] FAIL rnd_grant[%0d]: got i=%b d=%b want i=%b d=%b", k, i_gnt, d_gnt, want_i, want_d); end
      n_cmp++; if (ram_write !== exp_we || ram_addr !== exp_addr || ram_data !== exp_data) begin n_fail++; $display("[TB] FAIL rnd_ram[%0d]: got %b/%h/%h want %b/%h/%h", k, ram_write, ram_addr, ram_data, exp_we, exp_addr, exp_data); end
      n_cmp++; if (i_rvalid !== exp_iv || i_rdata !== exp_id) begin n_fail++; $display("[TB] FAIL rnd_i_resp[%0d]: got %b/%h want %b/%h", k, i_rvalid, i_rdata, exp_iv, exp_id); end
      n_cmp++; if (d_done !== exp_dv || d_rdata !== exp_dd) begin n_fail++; $display("[TB] FAIL rnd_d_resp[%0d]: got %b/%h want %b/%h", k, d_done, d_rdata, exp_dv, exp_dd); end
      exp_iv = want_i;
      exp_id = want_i ? shadow[i_addr[5:0]] : '0;
      exp_dv = want_d;
      exp_dd = (want_d && !d_we) ? shadow[d_addr[5:0]] : '0;
      if (want_d && d_we) shadow[d_addr[5:0]] = d_wdata;
      if (!i_req || want_i) m_cnt = 0;
      else if (want_d && m_cnt < SMAX) m_cnt++;
      tick();
      if (want_i) i_req = 1'b0;
      if (want_d) d_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++; if (i_rvalid !== exp_iv || i_rdata !== exp_id || d_done !== exp_dv || d_rdata !== exp_dd) begin n_fail++; $display("[TB] FAIL rnd_last_resp: got %b/%h %b/%h want %b/%h %b/%h", i_rvalid, i_rdata, d_done, d_rdata, exp_iv, exp_id, exp_dv, exp_dd); end
    tick();
  endtask

  initial begin
    tb_load = 1'b0; tb_load_addr = '0; tb_load_data = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_simultaneous();
    test_reset_mid();
    test_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
